// File: rtl/systolic_drain.sv
// systolic_drain: deskews the skewed column sums leaving the array, buffers aligned rows
// and serialises them one word per cycle. Define DRAIN_RELU_EN to zero negative words at the FIFO write.
module systolic_drain #(
    parameter int COLS      = 4,
    parameter int ACC_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [COLS*ACC_WIDTH-1:0] acc_in,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(COLS)-1:0]   out_col,
    output logic                      out_last,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);
    localparam int COL_W = $clog2(COLS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ROW_W = COLS * ACC_WIDTH;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [COLS-2:0]  vld_q, vld_d;
    logic [ROW_W-1:0] row_aligned;
    logic [ROW_W-1:0] wr_row;
    logic [ROW_W-1:0] head_row;
    logic [ROW_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             row_wr, push, pop, fire;

    // Deskew: lane c is delayed COLS-1-c cycles so every lane lands on the row-write cycle.
    for (genvar c = 0; c < COLS - 1; c++) begin : g_skew
        localparam int N = COLS - 1 - c;
        logic [ACC_WIDTH-1:0] dly_q [N];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < N; k++) dly_q[k] <= '0;
            end else begin
                dly_q[0] <= acc_in[c*ACC_WIDTH +: ACC_WIDTH];
                for (int k = 1; k < N; k++) dly_q[k] <= dly_q[k-1];
            end
        end

        assign row_aligned[c*ACC_WIDTH +: ACC_WIDTH] = dly_q[N-1];
    end
    assign row_aligned[(COLS-1)*ACC_WIDTH +: ACC_WIDTH] = acc_in[(COLS-1)*ACC_WIDTH +: ACC_WIDTH];

`ifdef DRAIN_RELU_EN
    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
        logic signed [ACC_WIDTH-1:0] w;
        logic signed [ACC_WIDTH-1:0] zero;
        zero     = '0;
        relu_row = row;
        for (int c = 0; c < COLS; c++) begin
            w = row[c*ACC_WIDTH +: ACC_WIDTH];
            if (w < zero) relu_row[c*ACC_WIDTH +: ACC_WIDTH] = '0;
        end
    endfunction

    assign wr_row = relu_row(row_aligned);
`else
    assign wr_row = row_aligned;
`endif

    assign row_wr    = vld_q[COLS-2];
    assign out_valid = (level_q != '0);
    assign fire      = out_valid && out_ready;
    assign pop       = fire && (col_q == COL_LAST);
    // A full FIFO still accepts the row when the head leaves on the same edge.
    assign push      = row_wr && ((level_q != LVL_FULL) || pop);

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = in_valid;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        col_d    = col_q;
        ovf_d    = ovf_q;
        if (fire)           col_d    = pop ? '0 : col_q + COL_W'(1);
        if (pop)            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push)           wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (row_wr && !push) ovf_d   = 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            col_q    <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            col_q    <= col_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_row;
    end

    assign head_row = mem_q[rd_ptr_q];

    // Serializer: data is forced to zero while empty so reset shows a clean bus.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < COLS; c++) begin
                if (COL_W'(c) == col_q) out_data = head_row[c*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    assign out_col  = col_q;
    assign out_last = out_valid && (col_q == COL_LAST);
    assign level    = level_q;
    assign full     = full_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed scenarios plus randomized traffic checked against a queue-based row model.
`timescale 1ns/1ps
module tb_systolic_drain;
    localparam int COLS  = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 2;
    typedef logic [COLS-1:0][AW-1:0] row_t;

    logic              clk = 1'b0;
    logic              reset, in_valid, out_ready;
    logic [COLS*AW-1:0] acc_in;
    logic [AW-1:0]     out_data;
    logic              out_valid, out_last, full, overflow;
    logic [1:0]        out_col;
    logic [1:0]        level;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // stimulus skew history: index d = row that started d cycles ago
    bit   hist_v [COLS];
    row_t hist_r [COLS];

    // reference model: buffered rows, pending rows with their due cycle
    row_t mq [$];
    int   pdue [$];
    row_t prow [$];
    int   mcol;
    bit   movf;

    systolic_drain #(.COLS(COLS), .ACC_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .acc_in(acc_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_last(out_last), .full(full), .level(level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog cyc %0d got timeout exp finish", cyc_n);
        $fatal(1);
    end

    function automatic row_t mk_row(input logic [AW-1:0] base);
        row_t r;
        for (int c = 0; c < COLS; c++) r[c] = base + AW'(c);
        return r;
    endfunction

    function automatic row_t clamp_ref(input row_t r);
        row_t o;
        o = r;
`ifdef DRAIN_RELU_EN
        for (int c = 0; c < COLS; c++) if (r[c][AW-1]) o[c] = '0;
`endif
        return o;
    endfunction

    task automatic model_clear();
        mq.delete();
        pdue.delete();
        prow.delete();
        mcol = 0;
        movf = 0;
        for (int d = 0; d < COLS; d++) begin
            hist_v[d] = 0;
            hist_r[d] = '0;
        end
    endtask

    task automatic step(input bit v, input row_t r, input bit rdy);
        bit mvalid, pop;
        for (int d = COLS - 1; d > 0; d--) begin
            hist_v[d] = hist_v[d-1];
            hist_r[d] = hist_r[d-1];
        end
        hist_v[0] = v;
        hist_r[0] = r;
        in_valid  = v;
        out_ready = rdy;
        for (int c = 0; c < COLS; c++)
            acc_in[c*AW +: AW] = hist_v[c] ? hist_r[c][c] : AW'($urandom);
        mvalid = (mq.size() != 0);
        if (v) begin
            pdue.push_back(cyc_n + COLS - 1);
            prow.push_back(r);
        end
        pop = mvalid && rdy && (mcol == COLS - 1);
        if (mvalid && rdy) mcol = (mcol + 1) % COLS;
        if (pop) void'(mq.pop_front());
        if (pdue.size() != 0 && pdue[0] == cyc_n) begin
            if (mq.size() < DEPTH) mq.push_back(clamp_ref(prow[0]));
            else movf = 1;
            void'(pdue.pop_front());
            void'(prow.pop_front());
        end
        @(posedge clk); #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_in = '0;
        @(posedge clk); #1;
        cyc_n++;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({out_valid, out_last, full, overflow, out_col, level} !== 8'h00) begin errors++;
            $display("FAIL reset_ctrl got %b exp 00000000", {out_valid, out_last, full, overflow, out_col, level}); end
        checks++; if (out_data !== '0) begin errors++;
            $display("FAIL reset_data got %0h exp 0", out_data); end
    endtask

    task automatic test_single_row();
        row_t r;
        r = mk_row(32'd1);
        do_reset();
        step(1, r, 1);
        for (int k = 1; k <= 3; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("FAIL single_early cyc %0d got %b exp 0", k, out_valid); end
            step(0, '0, 1);
        end
        checks++; if (level !== 2'd1) begin errors++;
            $display("FAIL single_level got %0d exp 1", level); end
        for (int k = 4; k <= 7; k++) begin
            checks++; if ({out_valid, out_data, out_col, out_last} !== {1'b1, 32'(k - 3), 2'(k - 4), (k == 7)}) begin errors++;
                $display("FAIL single_word cyc %0d got v%b d%0h c%0d l%b exp d%0h c%0d", k, out_valid, out_data, out_col, out_last, k - 3, k - 4); end
            step(0, '0, 1);
        end
        checks++; if ({out_valid, level} !== 3'b000) begin errors++;
            $display("FAIL single_drained got v%b lvl%0d exp v0 lvl0", out_valid, level); end
    endtask

    task automatic test_backpressure();
        row_t r;
        r = mk_row(32'd1);
        do_reset();
        step(1, r, 1);
        for (int k = 1; k <= 3; k++) step(0, '0, 1);
        for (int k = 4; k <= 6; k++) begin
            checks++; if ({out_valid, out_data, out_col, out_last} !== {1'b1, 32'd1, 2'd0, 1'b0}) begin errors++;
                $display("FAIL bp_hold cyc %0d got d%0h c%0d exp d1 c0", k, out_data, out_col); end
            step(0, '0, 0);
        end
        for (int k = 7; k <= 10; k++) begin
            checks++; if ({out_valid, out_data, out_col} !== {1'b1, 32'(k - 6), 2'(k - 7)}) begin errors++;
                $display("FAIL bp_word cyc %0d got d%0h c%0d exp d%0h c%0d", k, out_data, out_col, k - 6, k - 7); end
            step(0, '0, 1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_end got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        row_t rows [3];
        for (int i = 0; i < 3; i++) rows[i] = mk_row(AW'(16 * (i + 1)));
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k == 8) begin
                checks++; if ({full, level, overflow} !== {1'b1, 2'd2, 1'b0}) begin errors++;
                    $display("FAIL ovf_full got f%b l%0d o%b exp f1 l2 o0", full, level, overflow); end
            end
            step(k % 4 == 0, rows[k / 4], 0);
        end
        checks++; if ({overflow, full, level} !== {1'b1, 1'b1, 2'd2}) begin errors++;
            $display("FAIL ovf_set got o%b f%b l%0d exp o1 f1 l2", overflow, full, level); end
        for (int j = 0; j < 8; j++) begin
            checks++; if ({out_valid, out_data} !== {1'b1, 32'(16 * (1 + j / 4) + j % 4)}) begin errors++;
                $display("FAIL ovf_drain j%0d got v%b d%0h exp d%0h", j, out_valid, out_data, 16 * (1 + j / 4) + j % 4); end
            step(0, '0, 1);
        end
        checks++; if ({out_valid, overflow} !== 2'b01) begin errors++;
            $display("FAIL ovf_sticky got v%b o%b exp v0 o1", out_valid, overflow); end
    endtask

    task automatic test_pop_push();
        row_t rows [3];
        for (int i = 0; i < 3; i++) rows[i] = mk_row(AW'(16 * (i + 1)));
        do_reset();
        for (int k = 0; k < 9; k++) step(k == 0 || k == 4, rows[k / 4], 0);
        checks++; if ({full, level} !== {1'b1, 2'd2}) begin errors++;
            $display("FAIL pp_full got f%b l%0d exp f1 l2", full, level); end
        step(1, rows[2], 1);
        for (int k = 10; k <= 12; k++) step(0, '0, 1);
        checks++; if ({level, full, overflow, out_col} !== {2'd2, 1'b1, 1'b0, 2'd0}) begin errors++;
            $display("FAIL pp_level got l%0d f%b o%b c%0d exp l2 f1 o0 c0", level, full, overflow, out_col); end
        for (int j = 0; j < 8; j++) begin
            checks++; if ({out_valid, out_data} !== {1'b1, 32'(16 * (2 + j / 4) + j % 4)}) begin errors++;
                $display("FAIL pp_drain j%0d got v%b d%0h exp d%0h", j, out_valid, out_data, 16 * (2 + j / 4) + j % 4); end
            step(0, '0, 1);
        end
        checks++; if ({out_valid, overflow} !== 2'b00) begin errors++;
            $display("FAIL pp_end got v%b o%b exp v0 o0", out_valid, overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, mk_row(32'h100), 1);
        step(1, mk_row(32'h200), 1);
        step(0, '0, 1);
        step(0, '0, 1);
        for (int k = 4; k <= 11; k++) begin
            if (k == 5) begin
                checks++; if (level !== 2'd2) begin errors++;
                    $display("FAIL b2b_level got %0d exp 2", level); end
            end
            checks++; if ({out_valid, out_data, out_col, out_last} !== {1'b1, 32'(256 * (1 + (k - 4) / 4) + (k - 4) % 4), 2'((k - 4) % 4), ((k - 4) % 4 == 3)}) begin errors++;
                $display("FAIL b2b_word cyc %0d got d%0h c%0d l%b", k, out_data, out_col, out_last); end
            step(0, '0, 1);
        end
        checks++; if ({out_valid, level, overflow} !== 4'b0000) begin errors++;
            $display("FAIL b2b_end got v%b l%0d o%b exp 0", out_valid, level, overflow); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        step(1, mk_row(32'd1), 1);
        step(0, '0, 1);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            checks++; if ({out_valid, out_last, full, overflow, out_col, level, out_data} !== '0) begin errors++;
                $display("FAIL midreset cyc %0d got v%b d%0h l%0d", k, out_valid, out_data, level); end
            step(0, '0, 1);
        end
    endtask

    task automatic test_clamp();
        row_t r, e;
        r[0] = 32'hFFFF_FFFE; r[1] = 32'd5; r[2] = 32'h8000_0000; r[3] = 32'h7FFF_FFFF;
`ifdef DRAIN_RELU_EN
        e[0] = 32'd0; e[1] = 32'd5; e[2] = 32'd0; e[3] = 32'h7FFF_FFFF;
`else
        e = r;
`endif
        do_reset();
        step(1, r, 1);
        for (int k = 1; k <= 3; k++) step(0, '0, 1);
        for (int c = 0; c < COLS; c++) begin
            checks++; if ({out_valid, out_data} !== {1'b1, e[c]}) begin errors++;
                $display("FAIL clamp lane%0d got %0h exp %0h", c, out_data, e[c]); end
            step(0, '0, 1);
        end
    endtask

    task automatic test_random();
        bit      ev, v, rdy;
        logic [AW-1:0] ed;
        row_t    r;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            ev = (mq.size() != 0);
            ed = ev ? mq[0][mcol] : '0;
            checks++; if ({out_valid, out_data, out_col, out_last} !== {ev, ed, 2'(mcol), ev && (mcol == COLS - 1)}) begin errors++;
                $display("FAIL rand_out i%0d got v%b d%0h c%0d l%b exp v%b d%0h c%0d", i, out_valid, out_data, out_col, out_last, ev, ed, mcol); end
            checks++; if ({level, full, overflow} !== {2'(mq.size()), mq.size() == DEPTH, movf}) begin errors++;
                $display("FAIL rand_stat i%0d got l%0d f%b o%b exp l%0d o%b", i, level, full, overflow, mq.size(), movf); end
            for (int c = 0; c < COLS; c++) r[c] = AW'($urandom);
            v   = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 5) == 0);
            rdy = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) != 0);
            step(v, r, rdy);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_in = '0;
        model_clear();
        test_reset();
        test_single_row();
        test_backpressure();
        test_overflow();
        test_pop_push();
        test_back_to_back();
        test_reset_midflight();
        test_clamp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
